// File: rtl/pm_loader_pkg.sv
// Shared types and widths for the program-memory loader.
package pm_loader_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam logic [DATA_W-1:0] DEFAULT_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    DATA,
    WR,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/pm_load_timer.sv
// Idle-cycle counter; tick fires on the enabled cycle that brings the count to TIMEOUT.
module pm_load_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Saturates so a long wait in SYNC cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (en && cnt != SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/pm_loader.sv
// Framed byte-stream loader into program memory; holds the CPU until a good checksum.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h00,
  parameter logic [DATA_W-1:0] SYNC_BYTE  = DEFAULT_SYNC,
  parameter int                TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              pm_wren,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  state_t            state, state_nxt;
  logic              accept, last_byte, csum_ok, timer_en, tick, launch;
  logic [8:0]        remain;
  logic [DATA_W-1:0] csum;

  assign accept    = in_valid && in_ready;
  assign last_byte = (remain == 9'd1);
  assign csum_ok   = (csum_add(csum, in_data) == '0);
  assign timer_en  = (state inside {SYNC, LEN, DATA, CSUM}) && !accept;
  assign launch    = (state inside {IDLE, DONE, ERR}) && start;

  pm_load_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (!timer_en),
    .en   (timer_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = SYNC;
      SYNC:            if (accept && in_data == SYNC_BYTE) state_nxt = LEN;
      LEN:             if (accept) state_nxt = DATA; else if (tick) state_nxt = ERR;
      DATA:            if (accept) state_nxt = WR;   else if (tick) state_nxt = ERR;
      WR:              state_nxt = last_byte ? CSUM : DATA;
      CSUM:            if (accept) state_nxt = csum_ok ? DONE : ERR;
                       else if (tick) state_nxt = ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready   <= 1'b0;
      pm_wren    <= 1'b0;
      pm_wr_addr <= START_ADDR;
      pm_wr_data <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      remain     <= '0;
      csum       <= '0;
    end else begin
      in_ready <= state_nxt inside {SYNC, LEN, DATA, CSUM};
      pm_wren  <= (state_nxt == WR);
      if (launch) begin
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        pm_wr_addr <= START_ADDR;
      end
      if (state == LEN && accept) begin
        remain <= (in_data == '0) ? 9'd256 : {1'b0, in_data};
        csum   <= '0;
      end
      if (state == DATA && accept) begin
        pm_wr_data <= in_data;
        csum       <= csum_add(csum, in_data);
      end
      if (state == WR) begin
        pm_wr_addr <= pm_wr_addr + 1'b1;
        remain     <= remain - 1'b1;
      end
      if (state == CSUM && state_nxt == DONE) begin
        cpu_hold  <= 1'b0;
        load_done <= 1'b1;
      end
      if (state != ERR && state_nxt == ERR) load_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader (START_ADDR=F0, TIMEOUT=8).
module tb_pm_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, pm_wren, cpu_hold, load_done, load_error;
  logic [7:0] pm_wr_addr, pm_wr_data;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];

  pm_loader #(
    .START_ADDR(8'hF0),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pm_wren   (pm_wren),
    .pm_wr_addr(pm_wr_addr),
    .pm_wr_data(pm_wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_wren) begin
      wa_q.push_back(pm_wr_addr);
      wd_q.push_back(pm_wr_data);
      if (in_ready) overlap++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte_ready: in_ready=%b after %0d cycles, required 1 (byte %h)", in_ready, n, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, pm_wren, cpu_hold, load_done, load_error} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: rdy/wren/hold/done/err=%b required 00000",
               {in_ready, pm_wren, cpu_hold, load_done, load_error});
    end
    checks++;
    if (pm_wr_addr !== 8'hF0 || pm_wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr_data: addr=%h data=%h required F0 00", pm_wr_addr, pm_wr_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: in_ready=%b required 0", in_ready);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] bytes [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    wa_q.delete(); wd_q.delete(); overlap = 0;
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL good_start: hold=%b rdy=%b required 1 1", cpu_hold, in_ready);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL good_flags: done=%b hold=%b err=%b required 1 0 0", load_done, cpu_hold, load_error);
    end
    checks++;
    if (wa_q.size() != 3) begin
      errors++;
      $display("FAIL good_wr_count: got %0d required 3", wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_q[i] !== 8'hF0 + 8'(i) || wd_q[i] !== bytes[i+2]) begin
          errors++;
          $display("FAIL good_wr%0d: %h@%h required %h@%h", i, wd_q[i], wa_q[i], bytes[i+2], 8'hF0 + 8'(i));
        end
      end
    end
    checks++;
    if (overlap != 0 || pm_wr_addr !== 8'hF3) begin
      errors++;
      $display("FAIL good_wr_ready: overlap=%0d addr=%h required 0 F3", overlap, pm_wr_addr);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] bytes [4] = '{8'hA5, 8'h01, 8'h40, 8'h00};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    checks++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL bad_start_clear: done=%b hold=%b required 0 1", load_done, cpu_hold);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    checks++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_flags: err=%b hold=%b done=%b rdy=%b required 1 1 0 0",
               load_error, cpu_hold, load_done, in_ready);
    end
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'hF0 || wd_q[0] !== 8'h40) begin
      errors++;
      $display("FAIL bad_write: n=%0d first=%h@%h required 1 40@F0", wa_q.size(), wd_q[0], wa_q[0]);
    end
  endtask

  task automatic test_garbage();
    logic [7:0] bytes [6] = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h81};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    pulse_start();
    foreach (bytes[i]) send_byte(bytes[i]);
    checks++;
    if (load_done !== 1'b1 || load_error !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL garbage_flags: done=%b err=%b hold=%b required 1 0 0", load_done, load_error, cpu_hold);
    end
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'hF0 || wd_q[0] !== 8'h7F) begin
      errors++;
      $display("FAIL garbage_write: n=%0d first=%h@%h required 1 7F@F0", wa_q.size(), wd_q[0], wa_q[0]);
    end
  endtask

  task automatic test_wrap_256();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'h01);
    send_byte(8'h00);
    checks++;
    if (wa_q.size() != 256) begin
      errors++;
      $display("FAIL wrap_count: got %0d required 256", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 8'hF0 || wa_q[15] !== 8'hFF || wa_q[16] !== 8'h00 || wa_q[255] !== 8'hEF) begin
        errors++;
        $display("FAIL wrap_addrs: %h %h %h %h required F0 FF 00 EF", wa_q[0], wa_q[15], wa_q[16], wa_q[255]);
      end
    end
    checks++;
    if (pm_wr_addr !== 8'hF0 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: addr=%h done=%b hold=%b required F0 1 0", pm_wr_addr, load_done, cpu_hold);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h01);
    repeat (8) @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b rdy=%b required 0 1", load_error, in_ready);
    end
    @(negedge clk);
    checks++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%b hold=%b rdy=%b required 1 1 0", load_error, cpu_hold, in_ready);
    end
    pulse_start();
    checks++;
    if (load_error !== 1'b0 || load_done !== 1'b0 || in_ready !== 1'b1 || pm_wr_addr !== 8'hF0) begin
      errors++;
      $display("FAIL timeout_restart: err=%b done=%b rdy=%b addr=%h required 0 0 1 F0",
               load_error, load_done, in_ready, pm_wr_addr);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL sync_no_timeout: err=%b rdy=%b required 0 1", load_error, in_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] bytes [5] = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'hF5};
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, pm_wren, cpu_hold, load_done, load_error} !== 5'b00000 ||
        pm_wr_addr !== 8'hF0 || pm_wr_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b addr=%h data=%h required 00000 F0 00",
               {in_ready, pm_wren, cpu_hold, load_done, load_error}, pm_wr_addr, pm_wr_data);
    end
    reset = 1'b1;
    @(negedge clk);
    wa_q.delete(); wd_q.delete();
    pulse_start();
    foreach (bytes[i]) send_byte(bytes[i]);
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || wa_q.size() != 2) begin
      errors++;
      $display("FAIL midreset_reload: done=%b hold=%b writes=%0d required 1 0 2", load_done, cpu_hold, wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 8'hF0 || wd_q[0] !== 8'h05 || wa_q[1] !== 8'hF1 || wd_q[1] !== 8'h06) begin
        errors++;
        $display("FAIL midreset_writes: %h@%h %h@%h required 05@F0 06@F1", wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_garbage();
    test_wrap_256();
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
